seq_bit_serializer: RTL and testbench

Upstream feeder for the serial sequence-detector stage. It accepts parallel words over a valid/ready handshake and shifts each word out one bit at a time on bit_out, which drives the detector's serial input directly. bit_en paces the bit rate. A one-word holding register lets consecutive words stream with no idle bits between them, so a pattern that spans a word boundary reaches the detector intact.

---
 rtl/seq_bit_serializer.sv | 116 +++++++++++
 tb/tb_seq_bit_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words are taken over valid/ready,
// and a one-word holding register lets consecutive words shift out with no idle bit between them.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hold_full;

  logic             w_accept;
  logic             w_shifting;
  logic             w_last;
  logic [WIDTH-1:0] w_shift_next;

  // Advance the shift register by one bit position, filling with zero.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = v << 1;
    end else begin
      res = v >> 1;
    end
    return res;
  endfunction

  // Handshake and last-bit decode.
  always_comb begin
    w_accept     = in_valid && !r_hold_full;
    w_shifting   = (r_state == S_SHIFT);
    w_last       = w_shifting && bit_en && (r_cnt == LAST_CNT);
    w_shift_next = shift_once(r_shift);
  end

  assign in_ready  = !r_hold_full;
  assign bit_valid = w_shifting;
  assign bit_out   = w_shifting && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
  assign word_done = w_last && !flush;
  assign busy      = w_shifting || r_hold_full;

  // Word holding, shifting and state sequencing; flush outranks accept, load and shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else begin
      // Accept cannot coincide with a hold-to-shift load: accept needs an empty hold.
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            r_shift     <= r_hold;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_en) begin
            if (r_cnt == LAST_CNT) begin
              r_cnt <= '0;
              if (r_hold_full) begin
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
              end else begin
                r_shift <= w_shift_next;
                r_state <= S_IDLE;
              end
            end else begin
              r_shift <= w_shift_next;
              r_cnt   <= r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus and are compared every cycle against a word-queue model of the serial stream.
module tb_seq_bit_serializer;
  localparam int W = 8;
  localparam logic [9:0] RESET_OBS = 10'b10000_10000;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, bit_en;
  logic [W-1:0] in_data;
  logic         m_ready, m_valid, m_bit, m_done, m_busy;
  logic         l_ready, l_valid, l_bit, l_done, l_busy;
  logic [9:0]   obs;

  int checks = 0;
  int errors = 0;

  // Model: words in flight (front = word on the wire), bit index into it, and the
  // one cycle after a word lands in an empty block before its first bit appears.
  logic [W-1:0] q[$];
  int           k = 0;
  bit           fresh = 1'b0;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_ready), .bit_en(bit_en), .bit_out(m_bit), .bit_valid(m_valid),
    .word_done(m_done), .busy(m_busy));

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_ready), .bit_en(bit_en), .bit_out(l_bit), .bit_valid(l_valid),
    .word_done(l_done), .busy(l_busy));

  assign obs = {m_ready, m_valid, m_bit, m_done, m_busy, l_ready, l_valid, l_bit, l_done, l_busy};

  always #5 clk = ~clk;

  function automatic logic [9:0] expected();
    logic [W-1:0] w;
    logic v, rdy, bm, bl, d, b;
    w   = (q.size() > 0) ? q[0] : '0;
    v   = (q.size() > 0) && !fresh;
    rdy = !((q.size() >= 2) || fresh);
    bm  = v ? w[W-1-k] : 1'b0;
    bl  = v ? w[k] : 1'b0;
    d   = v && bit_en && (k == W - 1) && !flush && reset;
    b   = (q.size() > 0);
    return {rdy, v, bm, d, b, rdy, v, bl, d, b};
  endfunction

  task automatic tick();
    bit acc, cons;
    acc  = in_valid && (q.size() < 2) && !fresh;
    cons = (q.size() > 0) && !fresh && bit_en;
    @(posedge clk);
    if (!reset || flush) begin
      q.delete(); k = 0; fresh = 1'b0;
    end else begin
      fresh = 1'b0;
      if (cons) begin
        k++;
        if (k == W) begin
          void'(q.pop_front());
          k = 0;
        end
      end
      if (acc) begin
        fresh = (q.size() == 0);
        q.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (obs !== RESET_OBS) begin
      errors++; $display("FAIL reset_hold: got %b want %b", obs, RESET_OBS);
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL reset_idle c=%0d: got %b want %b", c, obs, expected());
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [W-1:0] col;
    int nv, nd, first;
    col = '0; nv = 0; nd = 0; first = -1;
    in_valid = 1'b1; in_data = 8'hB0; bit_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL single c=%0d: got %b want %b", c, obs, expected());
      end
      if (m_valid) begin
        nv++;
        if (first < 0) first = c;
        col = {col[W-2:0], m_bit};
      end
      if (m_done) nd++;
      tick();
    end
    checks++;
    if (col !== 8'hB0) begin errors++; $display("FAIL single_bits: got %h want b0", col); end
    checks++;
    if (nv != 8 || nd != 1) begin
      errors++; $display("FAIL single_counts: valid %0d done %0d want 8 1", nv, nd);
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL single_latency: first %0d want 2", first); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] col;
    int nv, sent, first, last, d1, d2;
    bit acc_now;
    col = '0; nv = 0; sent = 0; first = -1; last = -1; d1 = -1; d2 = -1;
    in_valid = 1'b1; in_data = 8'h0B; bit_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL b2b c=%0d: got %b want %b", c, obs, expected());
      end
      if (m_valid) begin
        nv++; last = c;
        if (first < 0) first = c;
        col = {col[14:0], m_bit};
      end
      if (m_done) begin
        if (d1 < 0) d1 = c; else d2 = c;
      end
      acc_now = in_valid && m_ready;
      tick();
      if (acc_now) begin
        sent++;
        if (sent == 1) in_data = 8'hB0; else in_valid = 1'b0;
      end
    end
    checks++;
    if (col !== 16'h0BB0) begin errors++; $display("FAIL b2b_bits: got %h want 0bb0", col); end
    checks++;
    if (nv != 16 || (last - first + 1) != 16) begin
      errors++; $display("FAIL b2b_contig: valid %0d span %0d want 16 16", nv, last - first + 1);
    end
    checks++;
    if ((d1 - first) != 7 || (d2 - first) != 15) begin
      errors++; $display("FAIL b2b_done: at %0d,%0d want 7,15", d1 - first, d2 - first);
    end
  endtask

  task automatic test_throttle();
    logic [W-1:0] col;
    int nv, nd;
    col = '0; nv = 0; nd = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    for (int c = 0; c < 30; c++) begin
      if (c == 1) in_valid = 1'b0;
      bit_en = (c % 3 == 1);
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL throttle c=%0d: got %b want %b", c, obs, expected());
      end
      if (m_valid) nv++;
      if (m_valid && bit_en) col = {col[W-2:0], m_bit};
      if (m_done) nd++;
      tick();
    end
    bit_en = 1'b1;
    checks++;
    if (col !== 8'hA5 || nv != 24 || nd != 1) begin
      errors++; $display("FAIL throttle_sum: bits %h valid %0d done %0d want a5 24 1", col, nv, nd);
    end
  endtask

  task automatic test_lsb();
    logic [W-1:0] col_m, col_l;
    col_m = '0; col_l = '0;
    in_valid = 1'b1; in_data = 8'h0D; bit_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL lsb c=%0d: got %b want %b", c, obs, expected());
      end
      if (m_valid) col_m = {col_m[W-2:0], m_bit};
      if (l_valid) col_l = {col_l[W-2:0], l_bit};
      tick();
    end
    checks++;
    if (col_l !== 8'hB0 || col_m !== 8'h0D) begin
      errors++; $display("FAIL lsb_bits: lsb %h msb %h want b0 0d", col_l, col_m);
    end
  endtask

  task automatic test_flush();
    int nc, nd, sent, fl_at;
    bit acc_now;
    nc = 0; nd = 0; sent = 0; fl_at = -1;
    in_valid = 1'b1; in_data = 8'hFF; bit_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      flush = (fl_at == c);
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL flush c=%0d: got %b want %b", c, obs, expected());
      end
      if (fl_at >= 0 && c == fl_at + 1) begin
        checks++;
        if (obs !== RESET_OBS) begin
          errors++; $display("FAIL flush_idle: got %b want %b", obs, RESET_OBS);
        end
      end
      if (m_valid && bit_en) nc++;
      if (m_done || l_done) nd++;
      acc_now = in_valid && m_ready;
      tick();
      if (acc_now) begin
        sent++;
        if (sent == 2) in_valid = 1'b0;
      end
      if (nc == 3 && fl_at < 0) fl_at = c + 1;
    end
    flush = 1'b0;
    checks++;
    if (nd != 0 || fl_at < 0) begin
      errors++; $display("FAIL flush_done: done %0d flush_at %0d want 0 >=0", nd, fl_at);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 8'hB0; bit_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL areset_pre c=%0d: got %b want %b", c, obs, expected());
      end
      tick();
    end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_OBS) begin
      errors++; $display("FAIL areset_now: got %b want %b", obs, RESET_OBS);
    end
    q.delete(); k = 0; fresh = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    test_single();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = W'($urandom);
      bit_en   = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      checks++;
      if (obs !== expected()) begin
        errors++; $display("FAIL random c=%0d: got %b want %b", c, obs, expected());
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; bit_en = 1'b0; in_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_throttle();
    test_lsb();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
